// File: rtl/ring_counter_pkg.sv
// Shared types and pattern helpers for the ring/Johnson counter family.
// Helpers work on a fixed maximum width; callers pass their own WIDTH and INIT_POS.
package ring_counter_pkg;

    localparam int unsigned RC_MAX_WIDTH = 64;

    typedef enum logic {RC_RING = 1'b0, RC_JOHNSON = 1'b1} rc_mode_e;
    typedef enum logic {RC_UP = 1'b0, RC_DOWN = 1'b1} rc_dir_e;

    function automatic logic [RC_MAX_WIDTH-1:0] home_pattern(rc_mode_e mode,
                                                             int unsigned init_pos);
        logic [RC_MAX_WIDTH-1:0] p;
        p = '0;
        if (mode == RC_RING) p[init_pos] = 1'b1;
        return p;
    endfunction

    // Johnson legal states are low-aligned or high-aligned runs of ones.
    function automatic logic is_legal(logic [RC_MAX_WIDTH-1:0] q, rc_mode_e mode,
                                      int unsigned width);
        logic [RC_MAX_WIDTH-1:0] mask;
        logic [RC_MAX_WIDTH-1:0] qm;
        logic [RC_MAX_WIDTH-1:0] nq;
        for (int unsigned i = 0; i < RC_MAX_WIDTH; i++) mask[i] = (i < width);
        qm = q & mask;
        nq = ~q & mask;
        if (mode == RC_RING) begin
            return (qm != '0) && ((qm & (qm - 1'b1)) == '0);
        end
        return ((qm & (qm + 1'b1)) == '0) || ((nq & (nq + 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/rc_legal_check.sv
// Combinational legality check of a counter state against the active mode.
module rc_legal_check
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic             legal
);

    logic [RC_MAX_WIDTH-1:0] q_ext;

    always_comb begin
        q_ext = '0;
        q_ext[WIDTH-1:0] = q;
        legal = is_legal(q_ext, rc_mode_e'(mode), WIDTH);
    end

endmodule

// File: rtl/ring_counter_param.sv
// WIDTH-bit ring / Johnson shift counter with direction, enable, load and wrap pulse.
// Define SELF_CORRECT_EN to force illegal states back to home and pulse err.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned INIT_POS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] home_mode, home_modeq;
    logic             wrap_q, wrap_d;
    rc_mode_e         mode_q;
    rc_mode_e         mode_in;

    logic [RC_MAX_WIDTH-1:0] home_mode_w, home_modeq_w;
    logic                    unused_home;

    assign mode_in      = rc_mode_e'(mode);
    assign home_mode_w  = home_pattern(mode_in, INIT_POS);
    assign home_modeq_w = home_pattern(mode_q, INIT_POS);
    assign home_mode    = home_mode_w[WIDTH-1:0];
    assign home_modeq   = home_modeq_w[WIDTH-1:0];
    assign unused_home  = ^{home_mode_w, home_modeq_w};

    always_comb begin
        shifted = cnt_q;
        unique case ({mode_q, rc_dir_e'(dir)})
            {RC_RING, RC_UP}:      shifted = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
            {RC_RING, RC_DOWN}:    shifted = {cnt_q[0], cnt_q[WIDTH-1:1]};
            {RC_JOHNSON, RC_UP}:   shifted = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
            {RC_JOHNSON, RC_DOWN}: shifted = {~cnt_q[0], cnt_q[WIDTH-1:1]};
            default:               shifted = cnt_q;
        endcase
    end

`ifdef SELF_CORRECT_EN
    logic legal;
    logic err_q, err_d;

    rc_legal_check #(
        .WIDTH(WIDTH)
    ) u_legal (
        .q    (cnt_q),
        .mode (mode_q),
        .legal(legal)
    );
`endif

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
`ifdef SELF_CORRECT_EN
        err_d  = 1'b0;
`endif
        if (load) begin
            cnt_d = load_val;
        end else if (mode_in != mode_q) begin
            cnt_d = home_mode;
`ifdef SELF_CORRECT_EN
        end else if (!legal) begin
            cnt_d = home_modeq;
            err_d = 1'b1;
`endif
        end else if (en) begin
            cnt_d  = shifted;
            wrap_d = (shifted == home_modeq);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= home_mode;
            mode_q <= mode_in;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_in;
            wrap_q <= wrap_d;
        end
    end

`ifdef SELF_CORRECT_EN
    always_ff @(posedge clk) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign q    = cnt_q;
    assign wrap = wrap_q;

endmodule
